// File: rtl/dff_pipeline_pkg.sv
// dff_pipeline shared types and helpers.
// Optional macro: DFF_PIPELINE_BUBBLE_COLLAPSE_EN.
package dff_pipeline_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [DEF_DEPTH-1:0] vld_vec_t;

endpackage

// File: rtl/dff_pipeline_if.sv
// dff_pipeline handshake/data bundle.
// Master drives words in; slave is the pipeline.
interface dff_pipeline_if
  import dff_pipeline_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  logic                      in_valid;
  logic [WIDTH-1:0]          d;
  logic                      in_ready;
  logic                      en;
  logic                      flush;
  logic [WIDTH-1:0]          q;
  logic                      out_valid;
  logic [cnt_w(DEPTH)-1:0]   occupancy;

  modport master (
    output in_valid, d, en, flush,
    input  in_ready, q, out_valid, occupancy
  );

  modport slave (
    input  in_valid, d, en, flush,
    output in_ready, q, out_valid, occupancy
  );

endinterface

// File: rtl/dff_pipeline_stage.sv
// dff_stage: one data register plus valid bit.
// Flush clears valid only; data holds.
module dff_stage #(
  parameter int             WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // reset > flush > load
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data  <= RST_VAL;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= i_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/dff_pipeline.sv
// dff_pipeline: DEPTH-stage valid-tagged delay line.
// Macro DFF_PIPELINE_BUBBLE_COLLAPSE_EN closes bubbles while stalled.
module dff_pipeline
  import dff_pipeline_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               DEPTH   = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic            clk,
  input logic            rst,
  dff_pipeline_if.slave  bus
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0]            w_v;
  logic [DEPTH-1:0]            w_ready;
  logic [DEPTH-1:0]            w_vin;
  logic [DEPTH-1:0][WIDTH-1:0] w_din;
  logic [DEPTH-1:0][WIDTH-1:0] w_data;
  logic [CW-1:0]               w_occ;

`ifdef DFF_PIPELINE_BUBBLE_COLLAPSE_EN
  // A stage may load if the head advances or any
  // stage at or after it is empty (unrolled ready chain).
  for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
    assign w_ready[i] = bus.en | ~(&w_v[DEPTH-1:i]);
  end
`else
  assign w_ready = {DEPTH{bus.en}};
`endif

  assign w_vin[0] = bus.in_valid;
  assign w_din[0] = bus.d;

  for (genvar i = 1; i < DEPTH; i++) begin : g_lnk
    assign w_vin[i] = w_v[i-1];
    assign w_din[i] = w_data[i-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    dff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_ready[i]),
      .i_flush (bus.flush),
      .i_valid (w_vin[i]),
      .i_data  (w_din[i]),
      .o_valid (w_v[i]),
      .o_data  (w_data[i])
    );
  end

  // popcount of the valid vector
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + CW'(w_v[i]);
    end
  end

  assign bus.in_ready  = w_ready[0];
  assign bus.q         = w_data[DEPTH-1];
  assign bus.out_valid = w_v[DEPTH-1];
  assign bus.occupancy = w_occ;

endmodule
